// File: rtl/fitness_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fitness_arbiter_if
//  Brief    : Requester and fitness-evaluator signal bundle of fitness_arbiter.
//  Revision : 1.0
// ============================================================================
interface fitness_arbiter_if #(
  parameter int REQUESTERS       = 4,
  parameter int INDIVIDUAL_WIDTH = 64,
  parameter int ERROR_WIDTH      = 5
);
  logic [REQUESTERS-1:0]                  req_valid;
  logic [REQUESTERS*INDIVIDUAL_WIDTH-1:0] req_individual;
  logic [REQUESTERS-1:0]                  req_ready;
  logic [REQUESTERS-1:0]                  resp_valid;
  logic [ERROR_WIDTH-1:0]                 resp_error;
  logic                                   resp_timeout;
  logic [INDIVIDUAL_WIDTH-1:0]            fit_individual;
  logic                                   fit_start;
  logic                                   fit_finish;
  logic [ERROR_WIDTH-1:0]                 fit_error;
  logic                                   busy;

  // The arbiter itself.
  modport master (
    input  req_valid, req_individual, fit_finish, fit_error,
    output req_ready, resp_valid, resp_error, resp_timeout,
           fit_individual, fit_start, busy
  );

  // Requesters plus fitness evaluator.
  modport slave (
    output req_valid, req_individual, fit_finish, fit_error,
    input  req_ready, resp_valid, resp_error, resp_timeout,
           fit_individual, fit_start, busy
  );
endinterface
`default_nettype wire

// File: rtl/fitness_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fitness_arbiter
//  Brief    : Round-robin sharing of one fitness evaluator among GA cores,
//             with start/finish handshake and watchdog abort.
//  Revision : 1.0
// ============================================================================
module fitness_arbiter #(
  parameter int REQUESTERS       = 4,
  parameter int INDIVIDUAL_WIDTH = 64,
  parameter int ERROR_WIDTH      = 5,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fitness_arbiter_if.master bus
);

  localparam int c_IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int c_SUM_W = c_IDX_W + 1;
  localparam int c_WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_WD_W-1:0]  c_WD_LAST   = c_WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_PTR_RESET = c_IDX_W'(REQUESTERS - 1);
  localparam logic [c_SUM_W-1:0] c_REQ_COUNT = c_SUM_W'(REQUESTERS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_nextState;
  logic [c_IDX_W-1:0]          r_ptr;
  logic [c_IDX_W-1:0]          w_winner;
  logic [c_SUM_W-1:0]          w_cand;
  logic                        w_anyValid;
  logic                        w_grant;
  logic                        w_wdExpired;
  logic                        w_fitStart;
  logic [INDIVIDUAL_WIDTH-1:0] r_individual;
  logic [c_WD_W-1:0]           r_watchdog;
  logic [ERROR_WIDTH-1:0]      r_respError;
  logic                        r_respTimeout;
  logic [REQUESTERS-1:0]       w_winnerOneHot;
  logic [REQUESTERS-1:0]       w_ptrOneHot;
  logic [REQUESTERS-1:0]       w_reqReady;
  logic [REQUESTERS-1:0]       w_respValid;
  logic [INDIVIDUAL_WIDTH-1:0] w_slice [REQUESTERS];

  genvar gi;
  generate
    for (gi = 0; gi < REQUESTERS; gi++) begin : g_req
      assign w_slice[gi]        = bus.req_individual[gi*INDIVIDUAL_WIDTH +: INDIVIDUAL_WIDTH];
      assign w_winnerOneHot[gi] = (w_winner == c_IDX_W'(gi));
      assign w_ptrOneHot[gi]    = (r_ptr == c_IDX_W'(gi));
    end
  endgenerate

  // Scan ptr+1, ptr+2, ... with wrap; the first pending requester wins.
  always_comb begin
    w_anyValid = 1'b0;
    w_winner   = r_ptr;
    w_cand     = '0;
    for (int k = 1; k <= REQUESTERS; k++) begin
      w_cand = {1'b0, r_ptr} + c_SUM_W'(k);
      if (w_cand >= c_REQ_COUNT) begin
        w_cand = w_cand - c_REQ_COUNT;
      end
      if (!w_anyValid && bus.req_valid[w_cand[c_IDX_W-1:0]]) begin
        w_anyValid = 1'b1;
        w_winner   = w_cand[c_IDX_W-1:0];
      end
    end
  end

  assign w_wdExpired = (r_watchdog == c_WD_LAST);
  assign w_grant     = (r_state == ST_IDLE) && w_anyValid;

  always_comb begin
    w_nextState = r_state;
    w_reqReady  = '0;
    w_respValid = '0;
    w_fitStart  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyValid) begin
          w_reqReady  = w_winnerOneHot;
          w_nextState = ST_START;
        end
      end
      ST_START: begin
        w_fitStart  = 1'b1;
        w_nextState = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.fit_finish || w_wdExpired) begin
          w_nextState = ST_RESP;
        end
      end
      ST_RESP: begin
        w_respValid = w_ptrOneHot;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr         <= c_PTR_RESET;
      r_individual  <= '0;
      r_watchdog    <= '0;
      r_respError   <= '0;
      r_respTimeout <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr        <= w_winner;
        r_individual <= w_slice[w_winner];
      end
      case (r_state)
        ST_START: r_watchdog <= '0;
        ST_WAIT: begin
          r_watchdog <= r_watchdog + 1'b1;
          // A finish arriving on the last watchdog cycle still counts as a result.
          if (bus.fit_finish) begin
            r_respError   <= bus.fit_error;
            r_respTimeout <= 1'b0;
          end else if (w_wdExpired) begin
            r_respError   <= '1;
            r_respTimeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The grant is combinational off req_valid, so it is masked while reset is held.
  assign bus.req_ready      = rst ? w_reqReady : '0;
  assign bus.resp_valid     = w_respValid;
  assign bus.resp_error     = r_respError;
  assign bus.resp_timeout   = r_respTimeout;
  assign bus.fit_individual = r_individual;
  assign bus.fit_start      = w_fitStart;
  assign bus.busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
